// File: rtl/clk_div_n_if.sv
// Control/status bundle for the clk_div_n programmable clock divider.
interface clk_div_n_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div;
    logic             load;
    logic             clko;
    logic             tick;
    logic             busy;
    logic             running;

    modport master (output en, div, load, input clko, tick, busy, running);
    modport slave  (input en, div, load, output clko, tick, busy, running);
endinterface

// File: rtl/clk_div_n.sv
// Even-ratio clock divider (ratio 2*(div+1)) with glitch-free ratio change and clean stop.
// Optional macro CLK_DIV_N_SYNC_EN adds a 2-flop synchroniser on en.
module clk_div_n #(
    parameter int DIV_W = 8
) (
    input  logic        clk1,
    input  logic        rst,
    clk_div_n_if.slave  bus
);
    // state    | meaning
    // IDLE     | clko held low, counter cleared, staged ratio applied at once
    // RUN      | dividing; ratio changes only at the clko falling boundary
    // STOPPING | en dropped during high phase; finish it, then IDLE
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_act, div_pend;
    logic             pend;
    logic             clko, clko_nxt;
    logic             tick, tick_nxt;
    logic             en_f;
    logic             tc;
    logic             apply;

`ifdef CLK_DIV_N_SYNC_EN
    logic [1:0] en_sync;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) en_sync <= 2'b00;
        else     en_sync <= {en_sync[0], bus.en};
    end

    assign en_f = en_sync[1];
`else
    assign en_f = bus.en;
`endif

    assign tc    = (cnt == div_act);
    assign apply = pend && ((state == IDLE) || (tc && clko));

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clko_nxt  = clko;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                clko_nxt = 1'b0;
                if (en_f) state_nxt = RUN;
            end
            RUN, STOPPING: begin
                // Stopping in the low phase wins over a pending rise: no runt high pulse.
                if (state == RUN && !en_f && !clko) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    if (tc) begin
                        cnt_nxt  = '0;
                        clko_nxt = ~clko;
                        tick_nxt = ~clko;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                    if (en_f)    state_nxt = RUN;
                    else if (tc) state_nxt = IDLE;
                    else         state_nxt = STOPPING;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clko     <= 1'b0;
            tick     <= 1'b0;
            div_act  <= '0;
            div_pend <= '0;
            pend     <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            clko <= clko_nxt;
            tick <= tick_nxt;
            if (apply) div_act <= div_pend;
            // A load coinciding with apply stays staged for the next boundary.
            if (bus.load) begin
                div_pend <= bus.div;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    assign bus.clko    = clko;
    assign bus.tick    = tick;
    assign bus.busy    = pend;
    assign bus.running = (state != IDLE);
endmodule

// File: tb/tb_clk_div_n.sv
// Scoreboard bench for clk_div_n: stimulus queues expected phase lengths, a monitor checks them.
module tb_clk_div_n;
    localparam int DIV_W = 8;
`ifdef CLK_DIV_N_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    clk_div_n_if #(.DIV_W(DIV_W)) bus();
    clk_div_n #(.DIV_W(DIV_W)) dut (.clk1(clk1), .rst(rst), .bus(bus));

    always #5 clk1 = ~clk1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];
    int   cur_d = 0;
    logic mon_prev_c = 1'b0;
    logic mon_prev_r = 1'b0;
    int   mon_since = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk1);
    endtask

    // Phase length = negedges since the last clko transition or since running rose.
    task automatic monitor();
        forever begin
            @(negedge clk1);
            if (rst) begin
                mon_prev_c = bus.clko;
                mon_prev_r = bus.running;
                mon_since  = 0;
            end else begin
                mon_since++;
                check("tick_pulse", int'(bus.tick), int'(bus.clko && !mon_prev_c));
                if (bus.clko != mon_prev_c) begin
                    if (exp_q.size() == 0)
                        check("edge_expected", 0, 1);
                    else
                        check(bus.clko ? "low_len" : "high_len", mon_since, exp_q.pop_front());
                    mon_since = 0;
                end
                if (bus.running && !mon_prev_r) mon_since = 0;
                mon_prev_c = bus.clko;
                mon_prev_r = bus.running;
            end
        end
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            cyc();
            if (bus.tick === 1'b1) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_clko(input logic v, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            cyc();
            if (bus.clko === v) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic start_run(input int d);
        bus.div  = d[DIV_W-1:0];
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        check("busy_after_load", int'(bus.busy), 1);
        cyc();
        check("busy_idle_apply", int'(bus.busy), 0);
        cur_d = d;
        exp_q.push_back(d + 1);
        bus.en = 1'b1;
        wait_tick("first_tick");
    endtask

    task automatic run_periods(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(cur_d + 1);
            exp_q.push_back(cur_d + 1);
            wait_tick("period_tick");
        end
    endtask

    // Called right after a tick; the new ratio takes effect from the next falling edge.
    task automatic load_seq(input int a, input int b, input bit two);
        int fin;
        fin = two ? b : a;
        bus.div  = a[DIV_W-1:0];
        bus.load = 1'b1;
        cyc();
        if (two) begin
            bus.div = b[DIV_W-1:0];
            cyc();
        end
        bus.load = 1'b0;
        check("busy_staged", int'(bus.busy), 1);
        exp_q.push_back(cur_d + 1);
        exp_q.push_back(fin + 1);
        wait_clko(1'b0, "fall_after_load");
        check("busy_applied", int'(bus.busy), 0);
        cur_d = fin;
        wait_tick("tick_new_ratio");
    endtask

    task automatic stop_high(input int extra);
        repeat (extra) cyc();
        bus.en = 1'b0;
        exp_q.push_back(cur_d + 1);
        wait_clko(1'b0, "stop_fall");
        check("stop_high_running", int'(bus.running), 0);
        repeat (cur_d + 3) cyc();
        check("stopped_clko", int'(bus.clko), 0);
        check("stopped_running", int'(bus.running), 0);
    endtask

    task automatic stop_low();
        exp_q.push_back(cur_d + 1);
        wait_clko(1'b0, "low_fall");
        check("running_before_stop", int'(bus.running), 1);
        bus.en = 1'b0;
        repeat (1 + SYNC_LAT) cyc();
        check("stop_low_running", int'(bus.running), 0);
        check("stop_low_clko", int'(bus.clko), 0);
        repeat (cur_d + 3) cyc();
        check("stop_low_held", int'(bus.clko), 0);
    endtask

    task automatic stop_resume();
        cyc();
        bus.en = 1'b0;
        cyc();
        bus.en = 1'b1;
        exp_q.push_back(cur_d + 1);
        exp_q.push_back(cur_d + 1);
        wait_tick("resume_tick");
        check("resume_running", int'(bus.running), 1);
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        #1;
        check("rst_clko", int'(bus.clko), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_tick", int'(bus.tick), 0);
        cyc();
        #2;
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        int lat;
        bit got;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.div  = '0;
        fork
            monitor();
        join_none
        repeat (3) cyc();
        check("init_clko", int'(bus.clko), 0);
        check("init_busy", int'(bus.busy), 0);
        check("init_running", int'(bus.running), 0);
        check("init_tick", int'(bus.tick), 0);
        #2;
        rst = 1'b0;
        cyc();

        // ratio 8, then mid-high change to ratio 4, then ratio 10 and stop at 2nd high cycle
        start_run(3);
        run_periods(2);
        load_seq(1, 0, 1'b0);
        run_periods(2);
        load_seq(4, 0, 1'b0);
        run_periods(1);
        stop_high(1);

        // ratio 2, ended by reset during the high phase
        start_run(0);
        run_periods(3);
        do_reset();
        check("queue_after_rst", exp_q.size(), 0);

        // back-to-back loads: only the last one is applied
        start_run(3);
        load_seq(7, 2, 1'b1);
        run_periods(2);
        load_seq(5, 0, 1'b0);
        run_periods(1);
        stop_resume();
        stop_low();

        // reset with a ratio staged; afterwards behaves as from power-up (ratio 2)
        start_run(5);
        bus.div  = 8'd9;
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        check("busy_before_rst", int'(bus.busy), 1);
        do_reset();
        exp_q.push_back(1);
        bus.en = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc();
            lat++;
            if (bus.tick === 1'b1) got = 1'b1;
        end
        check("first_tick_latency", lat, 2 + SYNC_LAT);
        cur_d = 0;
        run_periods(2);
        do_reset();

        for (int s = 0; s < 8; s++) begin
            int nd;
            start_run(int'($urandom_range(4, 10)));
            run_periods(int'($urandom_range(1, 2)));
            nd = int'($urandom_range(2, 10));
            if ($urandom_range(0, 1) == 1) load_seq(int'($urandom_range(0, 15)), nd, 1'b1);
            else                           load_seq(nd, 0, 1'b0);
            run_periods(1);
            case ($urandom_range(0, 2))
                0: stop_high(int'($urandom_range(0, cur_d - 2)));
                1: stop_low();
                default: begin
                    if (cur_d >= 4) stop_resume();
                    stop_low();
                end
            endcase
            check("queue_drained", exp_q.size(), 0);
        end

        repeat (4) cyc();
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL provide parameter: DIV_W, default 8, width of the divide-control field (ratio = 2*(div+1), range 2..2^(DIV_W+1)).
REQ-002 SHALL have port: clk1  input  1  source clock; all logic on posedge clk1.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: en  input  1  run request; 1 = divide, 0 = stop clko low.
REQ-005 SHALL have port: div  input  DIV_W  requested half-period minus one, sampled only when load=1.
REQ-006 SHALL have port: load  input  1  single-cycle request to stage div as the next ratio.
REQ-007 SHALL have port: clko  output  1  registered divided clock, 50% duty.
REQ-008 SHALL have port: tick  output  1  one-clk1-cycle pulse, high in the cycle clko goes 0->1.
REQ-009 SHALL have port: busy  output  1  staged ratio not yet applied.
REQ-010 SHALL have port: running  output  1  FSM not in IDLE.

Function
REQ-011 SHALL hold registers: cnt[DIV_W], div_act[DIV_W], div_pend[DIV_W], pend, clko, tick, FSM state {IDLE, RUN, STOPPING}.
REQ-012 SHALL, in RUN/STOPPING, define terminal count (TC) as cnt==div_act; on TC: cnt<=0, clko<=~clko; else cnt<=cnt+1 (DIV_W-bit, no wrap beyond div_act).
REQ-013 SHALL assert tick for exactly the cycle in which clko is registered 0->1; tick=0 otherwise.
REQ-014 SHALL, on load=1, capture div into div_pend and set pend=1; load while pend=1 overwrites div_pend.
REQ-015 SHALL apply div_pend only at a period boundary: TC with clko==1 (clko falling), or any cycle in IDLE; apply = div_act<=div_pend, pend<=0.
REQ-016 SHALL, if load and apply coincide, apply the previously staged value and keep the new div staged (pend stays 1).
REQ-017 SHALL drive busy=pend.
REQ-018 SHALL transition IDLE->RUN when en=1: cnt<=0, clko stays 0; first tick occurs div_act+1 cycles after RUN entry.
REQ-019 SHALL, in RUN with en=0 and clko==0: go IDLE next cycle, cnt<=0, clko held 0.
REQ-020 SHALL, in RUN with en=0 and clko==1: go STOPPING; high phase completes at TC (clko->0), then IDLE.
REQ-021 SHALL, in STOPPING with en=1: return to RUN with no disturbance to cnt/clko.
REQ-022 SHALL never produce a clko high or low phase shorter than div_act+1 cycles while en=1.
REQ-023 SHALL drive running=1 in RUN and STOPPING, 0 in IDLE.

Reset
REQ-024 SHALL, on rst=1, immediately force: state=IDLE, cnt=0, div_act=0, div_pend=0, pend=0, clko=0, tick=0; busy=0, running=0.
REQ-025 SHALL, on rst mid-period, discard pending ratio and partial phase; after release, behave as from power-up.

Configuration
REQ-026 SHALL recognise macro CLK_DIV_N_SYNC_EN.
REQ-027 SHALL, with CLK_DIV_N_SYNC_EN defined, pass en through a 2-flop clk1 synchroniser (reset to 0), adding 2 cycles of en-to-FSM latency.
REQ-028 SHALL, without CLK_DIV_N_SYNC_EN, use en directly (en assumed synchronous to clk1).

Verification
REQ-029 SHALL cover: rst release, load div=3, en=1 -> clko period 8 cycles, 4 high/4 low, tick every 8 cycles, busy low 1 cycle after load (IDLE apply).
REQ-030 SHALL cover: running div=3, load div=1 mid high phase -> busy=1 until clko falls, then period 4 (2/2), no short phase.
REQ-031 SHALL cover: div=0 -> clko toggles every cycle (ratio 2), tick every 2 cycles.
REQ-032 SHALL cover: div=4, en=0 at 2nd high cycle -> STOPPING, clko falls after 5th high cycle, running=0 next cycle; en=0 in low phase -> IDLE next cycle, clko=0.
REQ-033 SHALL cover: load div=7 and div=2 back-to-back while running -> only div=2 applied at next boundary.
REQ-034 SHALL cover: rst pulse mid high phase with pend=1 -> clko=0, busy=0, running=0 asynchronously; with CLK_DIV_N_SYNC_EN, first tick delayed 2 extra cycles vs. without.
